// File: rtl/apb_mem_slave.sv
// APB slave bridging single transfers onto a simple synchronous memory port.
// Define APB_SLV_ERR_EN to flag misaligned and out-of-range addresses with pslverr.
module apb_mem_slave #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_BYTES   = 1024,
    parameter int unsigned WAIT_CYCLES = 0,
    localparam int unsigned NB         = DATA_WIDTH / 8,
    localparam int unsigned DEPTH      = MEM_BYTES / NB,
    localparam int unsigned IW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic [NB-1:0]         pstrb,
    output logic                  pready,
    output logic                  pslverr,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [NB-1:0]         mem_be,
    output logic [IW-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int unsigned OW = $clog2(NB);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NB-1:0]         strb_q, strb_d;
    logic                  err;
    logic                  access;

`ifdef APB_SLV_ERR_EN
    localparam int unsigned MW = $clog2(MEM_BYTES);
    logic misaligned;
    logic out_of_range;

    assign misaligned   = |(addr_q & ADDR_WIDTH'(NB - 1));
    assign out_of_range = |(addr_q >> MW);
    assign err          = misaligned | out_of_range;
`else
    // Low byte-offset bits and bits above the memory size are dropped, so accesses wrap.
    logic unused_addr;

    assign unused_addr = ^addr_q;
    assign err         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        case (state_q)
            StIdle: begin
                // psel with penable already high is a protocol violation and is ignored.
                if (psel && !penable) begin
                    state_d = StWait;
                    cnt_d   = 4'(WAIT_CYCLES);
                    addr_d  = paddr;
                    write_d = pwrite;
                    wdata_d = pwdata;
                    strb_d  = pstrb;
                end
            end
            StWait: begin
                if (!psel) begin
                    state_d = StIdle;
                end else if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Memory strobe fires in the last wait cycle so read data lines up with the response cycle.
    assign access = (state_q == StWait) && (cnt_q == 4'd0) && psel && !err && !rst;

    always_comb begin
        mem_we    = access && write_q;
        mem_re    = access && !write_q;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (mem_we) begin
            mem_be = strb_q;
        end else if (mem_re) begin
            mem_be = '1;
        end
        if (access) begin
            mem_addr  = addr_q[OW +: IW];
            mem_wdata = wdata_q;
        end
        pready  = (state_q == StResp) && !rst;
        pslverr = pready && err;
        prdata  = '0;
        if (pready && !err && !write_q) begin
            prdata = mem_rdata;
        end
    end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave with a memory model and a scoreboard of expected strobes.
module tb_apb_mem_slave;

    localparam int unsigned WAIT = 2;
`ifdef APB_SLV_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;
    logic        mem_we;
    logic        mem_re;
    logic [3:0]  mem_be;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_op_t;

    mem_op_t     exp_q[$];
    mem_op_t     mon_e;
    logic [31:0] mem [256];
    int          checks = 0;
    int          failures = 0;
    logic        mon_en = 1'b0;

    always #5 clk = ~clk;

    apb_mem_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_BYTES  (1024),
        .WAIT_CYCLES(WAIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .pstrb    (pstrb),
        .pready   (pready),
        .pslverr  (pslverr),
        .prdata   (prdata),
        .mem_we   (mem_we),
        .mem_re   (mem_re),
        .mem_be   (mem_be),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Memory model: byte-enabled writes, read data one cycle after mem_re.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem_rdata <= '0;
        end else begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
            if (mem_re) mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every memory strobe must match the next scoreboard entry; idle cycles must be quiet.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_we || mem_re) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", 64'(mem_we | mem_re), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("mem_we", 64'(mem_we), 64'(mon_e.we));
                    chk("mem_re", 64'(mem_re), 64'(!mon_e.we));
                    chk("mem_addr", 64'(mem_addr), 64'(mon_e.addr));
                    chk("mem_be", 64'(mem_be), 64'(mon_e.be));
                    chk("mem_wdata", 64'(mem_wdata), 64'(mon_e.wdata));
                end
            end else begin
                chk("mem_idle", 64'({mem_addr, mem_be, mem_wdata}), 64'd0);
            end
            if (pready !== 1'b1) chk("rsp_idle", 64'({pready, pslverr, prdata}), 64'd0);
        end
    end

    task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        input logic exp_err, input logic [31:0] exp_rdata);
        logic    pulse_exp;
        logic    done;
        int      n;
        mem_op_t op;
        pulse_exp = !exp_err;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
        if (pulse_exp) begin
            op.we    = wr;
            op.addr  = addr[9:2];
            op.be    = wr ? strb : 4'hF;
            op.wdata = data;
            exp_q.push_back(op);
        end
        @(posedge clk); #1;
        penable = 1'b1;
        done = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            n++;
            @(negedge clk);
            chk({tag, "_pulse"}, 64'(mem_we | mem_re), 64'(pulse_exp && (n == WAIT + 1)));
            done = (pready === 1'b1);
        end
        chk({tag, "_ready"}, 64'(done), 64'd1);
        chk({tag, "_latency"}, 64'(n), 64'(WAIT + 2));
        chk({tag, "_pslverr"}, 64'(pslverr), 64'(exp_err));
        chk({tag, "_prdata"}, 64'(prdata), 64'((wr || exp_err) ? 32'd0 : exp_rdata));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_rsp", 64'({pready, pslverr, prdata}), 64'd0);
        chk("reset_mem", 64'({mem_we, mem_re, mem_be, mem_addr, mem_wdata}), 64'd0);
        mon_en = 1'b1;

        xfer("wr_basic", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
        xfer("rd_basic", 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF);
        xfer("wr_nostrb", 1'b1, 32'h10, 32'h0BADF00D, 4'h0, 1'b0, 32'h0);
        xfer("rd_kept", 1'b0, 32'h10, 32'h5A5A5A5A, 4'h3, 1'b0, 32'hDEADBEEF);

        xfer("b2b_wr0", 1'b1, 32'h0, 32'h11223344, 4'h3, 1'b0, 32'h0);
        xfer("b2b_wr4", 1'b1, 32'h4, 32'hAABBCCDD, 4'hC, 1'b0, 32'h0);
        xfer("rd_w0", 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 32'h00003344);
        xfer("rd_w4", 1'b0, 32'h4, 32'h0, 4'hF, 1'b0, 32'hAABB0000);

        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h8; pstrb = 4'hF;
        repeat (4) begin
            @(negedge clk);
            chk("violation_ready", 64'(pready), 64'd0);
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;

        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h10;
        @(posedge clk); #1;
        psel = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("drop_ready", 64'(pready), 64'd0);
        end
        xfer("rd_after_drop", 1'b0, 32'h4, 32'h0, 4'h0, 1'b0, 32'hAABB0000);

        xfer("wr_oob", 1'b1, 32'h400, 32'h55667788, 4'hF, ERR_EN, 32'h0);
        xfer("rd_unaligned", 1'b0, 32'h13, 32'h0, 4'h0, ERR_EN, 32'hDEADBEEF);
        xfer("rd_after_oob", 1'b0, 32'h0, 32'h0, 4'h0, 1'b0,
             ERR_EN ? 32'h00003344 : 32'h55667788);

        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20;
        pwdata = 32'h12345678; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_no_pulse", 64'({mem_we, mem_re}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk("rst_rsp_zero", 64'({pready, pslverr, prdata}), 64'd0);
        chk("rst_mem_zero", 64'({mem_we, mem_re, mem_be, mem_addr, mem_wdata}), 64'd0);
        xfer("rd_after_rst", 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'h0);

        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_mem_slave.md
APB_MEM_SLAVE -- requirements
Module: apb_mem_slave

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, data width; legal values 8/16/32/64; NB = DATA_WIDTH/8.
REQ-003 The block SHALL have parameter MEM_BYTES, default 1024, memory size; a power of two and a multiple of NB; DEPTH = MEM_BYTES/NB; IW = clog2(DEPTH).
REQ-004 The block SHALL have parameter WAIT_CYCLES, default 0, extra access-phase wait states; legal range 0..15.
REQ-005 The block SHALL have these ports:
- clk  in  1  clock, all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- psel  in  1  slave select.
- penable  in  1  access phase.
- pwrite  in  1  1 = write.
- paddr  in  ADDR_WIDTH  byte address.
- pwdata  in  DATA_WIDTH  write data.
- pstrb  in  NB  write byte strobes.
- pready  out  1  transfer complete.
- pslverr  out  1  transfer error.
- prdata  out  DATA_WIDTH  read data.
- mem_we  out  1  memory write pulse.
- mem_re  out  1  memory read pulse.
- mem_be  out  NB  memory byte enables.
- mem_addr  out  IW  word index.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  read data, valid the cycle after mem_re.

Function
REQ-006 The FSM SHALL have three states, IDLE, WAIT and RESP.
- IDLE->WAIT when psel=1 and penable=0; paddr, pwrite, pwdata and pstrb are captured; cnt <= WAIT_CYCLES.
- WAIT: cnt decrements each cycle; when cnt==0 the next state is RESP.
- RESP->IDLE unconditionally.
REQ-007 A transfer SHALL be erroneous when the captured paddr is not NB-aligned or is >= MEM_BYTES.
REQ-008 In the WAIT cycle with cnt==0 and psel=1, for a non-erroneous transfer, the block SHALL assert exactly one of the following for one cycle:
- write: mem_we=1, mem_be=captured pstrb.
- read: mem_re=1, mem_be=all ones.
REQ-009 In that same cycle mem_addr SHALL equal captured paddr/NB (low IW bits) and mem_wdata SHALL equal captured pwdata; all mem_* outputs SHALL be 0 in every other cycle.
REQ-010 The block SHALL assert pready=1 only in RESP, so the access phase lasts WAIT_CYCLES+2 cycles.
REQ-011 In RESP, prdata SHALL equal mem_rdata for a non-erroneous read; otherwise prdata SHALL be 0.
REQ-012 In RESP, pslverr SHALL equal 1 for an erroneous transfer; otherwise pslverr SHALL be 0.
REQ-013 A write with pstrb==0 SHALL complete normally and assert mem_we with mem_be=0.
REQ-014 pstrb SHALL be ignored for reads.
REQ-015 If psel=0 in any WAIT cycle, the block SHALL return to IDLE next cycle with no mem_* pulse and no pready.
REQ-016 Back-to-back transfers SHALL be supported: a setup phase in the cycle after RESP is accepted from IDLE with no extra idle cycle.
REQ-017 psel=1 with penable=1 while in IDLE (protocol violation) SHALL be ignored.

Reset
REQ-018 When rst=1 at a clock edge, the next state SHALL be IDLE, cnt and all captured registers SHALL be 0, and pready, pslverr, prdata and all mem_* outputs SHALL be 0.
REQ-019 A reset asserted mid-transfer SHALL abort it with no memory pulse in or after the reset cycle.

Configuration
REQ-020 With macro APB_SLV_ERR_EN defined, the error checks of REQ-007 and REQ-012 SHALL be active.
REQ-021 Without APB_SLV_ERR_EN, pslverr SHALL be tied 0, address low bits below NB SHALL be ignored, and out-of-range addresses SHALL wrap modulo MEM_BYTES with a normal memory access.

Verification (DATA_WIDTH=32, MEM_BYTES=1024, WAIT_CYCLES=2, APB_SLV_ERR_EN unless noted)
REQ-022 Write paddr=0x10, pwdata=0xDEADBEEF, pstrb=0xF -> one mem_we pulse with mem_addr=4 and mem_be=0xF; pready high 4 cycles after the setup cycle; pslverr=0.
REQ-023 Read paddr=0x10 with the model returning 0xDEADBEEF -> one mem_re pulse; prdata=0xDEADBEEF in the pready cycle; prdata=0 in all other cycles.
REQ-024 Write paddr=0x400 and read paddr=0x13 -> no mem pulse, pslverr=1 and prdata=0 in RESP; without APB_SLV_ERR_EN, paddr=0x400 writes mem_addr=0 with pslverr=0.
REQ-025 Two back-to-back writes, 0x0 with pstrb=0x3 then 0x4 with pstrb=0xC -> mem_be=0x3 then 0xC; the second setup is accepted in the cycle after the first pready.
REQ-026 Drop psel in the first WAIT cycle -> no mem pulse, no pready, and a following read completes normally.
REQ-027 Assert rst in the WAIT cycle with cnt==0 -> no mem pulse and all outputs 0 next cycle.
